systolic_feeder: RTL and testbench

Upstream control and data-staging stage for `systolicArray`. It accepts one pair of N×N 8-bit matrices A and B over a valid/ready handshake and drives the array's skewed row/column operand windows and `i_doProcess` for exactly the required number of cycles. It then captures the array's N×N 32-bit results and returns C = A×B on a valid/ready result port. The array's accumulators are never cleared between jobs, so the block computes each job's result as a difference from a per-job baseline.

---
 rtl/systolic_feeder.sv | 72 +++++++
 tb/tb_systolic_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: stages one A/B job into a systolic array and returns C=A*B as the accumulator delta over the job.
module systolic_feeder #(
  parameter int N = 4
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [N-1:0][N-1:0][7:0]     i_a,
  input  logic [N-1:0][N-1:0][7:0]     i_b,
  output logic                         o_doProcess,
  output logic [N-1:0][2*N-2:0][7:0]   o_row,
  output logic [N-1:0][2*N-2:0][7:0]   o_col,
  input  logic [N-1:0][N-1:0][31:0]    i_c,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [N-1:0][N-1:0][31:0]    o_c
);
  localparam int W = 2*N-1;
  localparam int CW = $clog2(3*N-2);
  localparam logic [CW-1:0] LAST = CW'(3*N-3);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [N-1:0][N-1:0][31:0] base;
  logic [N-1:0][W-1:0][7:0] row_ld, col_ld, row_sh, col_sh;
  logic accept;
  assign accept = i_valid & o_ready;
  for (genvar i = 0; i < N; i++) begin : g_win
    assign row_sh[i] = {8'd0, o_row[i][W-1:1]};
    assign col_sh[i] = {8'd0, o_col[i][W-1:1]};
    for (genvar k = 0; k < W; k++) begin : g_k
      if (k >= i && k < i + N) begin : g_in
        assign row_ld[i][k] = i_a[i][k-i];
        assign col_ld[i][k] = i_b[k-i][i];
      end else begin : g_out
        assign row_ld[i][k] = 8'd0;
        assign col_ld[i][k] = 8'd0;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE  ? (i_valid ? RUN : IDLE) :
                 state == RUN   ? (cnt == LAST ? DRAIN : RUN) :
                 state == DRAIN ? DONE :
                 (i_ready ? IDLE : DONE);
  always_comb begin
    o_ready = state == IDLE;
    o_doProcess = state == RUN;
    o_valid = state == DONE;
  end
  // Windows shift toward index 0 while running and sit at zero otherwise.
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      cnt <= '0;
      o_row <= '0;
      o_col <= '0;
      base <= '0;
      o_c <= '0;
    end else begin
      cnt <= accept ? '0 : state == RUN ? cnt + 1'b1 : cnt;
      o_row <= accept ? row_ld : state == RUN ? row_sh : '0;
      o_col <= accept ? col_ld : state == RUN ? col_sh : '0;
      base <= accept ? i_c : base;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          o_c[i][j] <= state == DRAIN ? i_c[i][j] - base[i][j] : o_c[i][j];
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random and directed jobs through a behavioural systolic array, checked against plain matrix products.
module tb_systolic_feeder;
  localparam int N = 4;
  typedef logic [N-1:0][N-1:0][7:0] mat8_t;
  typedef logic [N-1:0][N-1:0][31:0] mat32_t;
  logic i_clk = 0, i_arst_n = 0, i_valid = 0, i_ready = 1;
  mat8_t i_a = '0, i_b = '0;
  logic o_ready, o_doProcess, o_valid;
  logic [N-1:0][2*N-2:0][7:0] o_row, o_col;
  mat32_t i_c, o_c;
  mat32_t acc, pre_val;
  logic pre_en = 0;
  logic [7:0] ah [N][N];
  logic [7:0] bv [N][N];
  int checks = 0, errors = 0;
  int cyc;

  systolic_feeder #(.N(N)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .o_doProcess(o_doProcess), .o_row(o_row), .o_col(o_col),
    .i_c(i_c), .o_valid(o_valid), .i_ready(i_ready), .o_c(o_c)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural array: operands hop one PE per cycle right (A) and down (B).
  function automatic logic [7:0] a_in(int i, int j);
    if (j == 0) return o_row[i][0];
    return ah[i][j-1];
  endfunction
  function automatic logic [7:0] b_in(int i, int j);
    if (i == 0) return o_col[j][0];
    return bv[i-1][j];
  endfunction
  assign i_c = acc;
  always @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      acc <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ah[i][j] <= 8'd0;
          bv[i][j] <= 8'd0;
        end
    end else if (pre_en) acc <= pre_val;
    else
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ah[i][j] <= o_doProcess ? a_in(i, j) : 8'd0;
          bv[i][j] <= o_doProcess ? b_in(i, j) : 8'd0;
          if (o_doProcess) acc[i][j] <= acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
        end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mat32_t matmul(mat8_t a, mat8_t b);
    mat32_t c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c[i][j] = 32'd0;
        for (int k = 0; k < N; k++) c[i][j] += 32'(a[i][k]) * 32'(b[k][j]);
      end
    return c;
  endfunction

  function automatic mat8_t rand_mat();
    mat8_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = 8'($urandom);
    return m;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input mat8_t a, input mat8_t b);
    int w = 0;
    while (!o_ready && w < 50) begin
      tick();
      w++;
    end
    chk("ready_before_accept", o_ready, 1);
    i_a = a;
    i_b = b;
    i_valid = 1;
    tick();
    i_valid = 0;
    i_a = rand_mat();
    i_b = rand_mat();
    cyc = 1;
  endtask

  task automatic job(input string tag, input mat8_t a, input mat8_t b, input int hold);
    mat32_t exp;
    int dp = 0;
    exp = matmul(a, b);
    start(a, b);
    while (!o_valid && cyc < 40) begin
      if (cyc <= 3*N-2)
        for (int i = 0; i < N; i++) begin
          logic [7:0] ea, eb;
          int t;
          t = cyc - 1;
          ea = 8'd0;
          eb = 8'd0;
          if (t >= i && t - i < N) begin
            ea = a[i][t-i];
            eb = b[t-i][i];
          end
          chk($sformatf("%s_row%0d_t%0d", tag, i, t), o_row[i][0], ea);
          chk($sformatf("%s_col%0d_t%0d", tag, i, t), o_col[i][0], eb);
        end
      dp += int'(o_doProcess);
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 3*N);
    chk({tag, "_doprocess_cycles"}, dp, 3*N-2);
    chk({tag, "_windows_zero"}, (o_row == '0) && (o_col == '0), 1);
    chk({tag, "_ready_in_done"}, o_ready, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), o_c[i][j], exp[i][j]);
    if (hold > 0) begin
      i_ready = 0;
      for (int h = 0; h < hold; h++) begin
        i_valid = 1'($urandom);
        tick();
        chk({tag, "_hold_valid"}, o_valid, 1);
        chk({tag, "_hold_ready"}, o_ready, 0);
        chk({tag, "_hold_c"}, o_c == exp, 1);
      end
      i_valid = 0;
      i_ready = 1;
    end
    tick();
    chk({tag, "_idle_after_hs"}, o_ready, 1);
    chk({tag, "_valid_after_hs"}, o_valid, 0);
    chk({tag, "_c_kept"}, o_c == exp, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    mat8_t ident, bseq, ones, maxm;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ident[i][j] = (i == j) ? 8'd1 : 8'd0;
        bseq[i][j] = 8'(i*N + j);
        ones[i][j] = 8'd1;
        maxm[i][j] = 8'd255;
      end
    tick();
    tick();
    i_arst_n = 1;
    tick();
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_doprocess", o_doProcess, 0);
    chk("rst_c", o_c == '0, 1);
    chk("rst_windows", (o_row == '0) && (o_col == '0), 1);

    job("ident", ident, bseq, 0);
    job("max", maxm, maxm, 0);
    chk("max_c00", o_c[0][0], 260100);
    job("ones_b2b", ones, ones, 0);
    chk("ones_c33", o_c[3][3], 4);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) pre_val[i][j] = 32'hFFFF_FFF0 + 32'(i*N + j);
    pre_en = 1;
    tick();
    pre_en = 0;
    job("wrap", ones, ones, 0);

    job("bp", rand_mat(), rand_mat(), 20);
    for (int r = 0; r < 4; r++) job($sformatf("rnd%0d", r), rand_mat(), rand_mat(), int'($urandom_range(0, 3)));

    start(ident, bseq);
    for (int k = 0; k < 5; k++) tick();
    chk("midrun_doprocess_before", o_doProcess, 1);
    i_arst_n = 0;
    #1;
    chk("midrun_rst_doprocess", o_doProcess, 0);
    chk("midrun_rst_valid", o_valid, 0);
    chk("midrun_rst_windows", (o_row == '0) && (o_col == '0), 1);
    chk("midrun_rst_c", o_c == '0, 1);
    tick();
    i_arst_n = 1;
    tick();
    chk("midrun_ready_after", o_ready, 1);
    job("post_rst_ident", ident, bseq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
